// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO drain-side burst reader.
//   state_t      - burst reader FSM state
//   buf_entry_t  - output-buffer entry {data, last} at the default FIFO width
//   DEF_*        - default parameter values shared with the FIFO
package fifo_pkg;

    localparam int DEF_DWIDTH    = 64;
    localparam int DEF_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WAIT_LAST
    } state_t;

    typedef struct packed {
        logic [DEF_DWIDTH-1:0] data;
        logic                  last;
    } buf_entry_t;

endpackage

// File: rtl/out_skid_buf.sv
// out_skid_buf: 2-entry valid/ready output buffer holding {data, last}.
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, push_data,
//   push_last           - write one entry (caller guarantees occupancy < 2)
//   set_last            - set the last bit of the youngest buffered entry
//   m_valid, m_ready,
//   m_data, m_last      - downstream stream, driven from the head entry
//   occupancy           - number of buffered entries (0..2)
module out_skid_buf #(
    parameter int DWIDTH = fifo_pkg::DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              push_last,
    input  logic              set_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        occupancy
);

    // Same layout as fifo_pkg::buf_entry_t, sized by this instance's DWIDTH.
    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
    } entry_t;

    entry_t     head_q, tail_q, head_d, tail_d;
    logic [1:0] occ_q, occ_d;
    logic       xfer;

    assign xfer      = (occ_q != 2'd0) && m_ready;
    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = head_q.data;
    // A single buffered entry being marked last must show m_last in the
    // same cycle, since it may be transferring right now.
    assign m_last    = head_q.last | (set_last & (occ_q == 2'd1));
    assign occupancy = occ_q;

    // Order matters: mark youngest, then shift out the head, then append.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (set_last) begin
            if (occ_q == 2'd1)
                head_d.last = 1'b1;
            else if (occ_q == 2'd2)
                tail_d.last = 1'b1;
        end
        if (xfer) begin
            head_d = tail_d;
            occ_d  = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0)
                head_d = {push_data, push_last};
            else
                tail_d = {push_data, push_last};
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops words from a first-word-fall-through FIFO and
// re-emits them downstream as fixed-length bursts with a last flag.
//   clk, rst            - clock, asynchronous active-low reset
//   enable              - start bursts back-to-back while high
//   flush               - pulse; end the current burst early
//   fifo_valid,
//   fifo_data           - FIFO head word
//   fifo_deque_en       - pop request (only asserted with fifo_valid)
//   m_valid, m_ready,
//   m_data, m_last      - downstream valid/ready stream
//   burst_done          - pulse when the last word of a burst transfers
//   burst_count         - completed bursts, wraps modulo 2^32
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_valid,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_deque_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              burst_done,
    output logic [31:0]       burst_count
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BURST_LEN);

    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic             term_pending;
    logic [1:0]       occupancy;

    logic buf_nonempty;
    logic pop_ok;
    logic natural_last;
    logic flush_hit;
    logic pop;
    logic set_last;
    logic push_last;

    assign buf_nonempty = (occupancy != 2'd0);
    assign pop_ok       = (state == BURST) && fifo_valid && (occupancy != 2'd2)
                          && (words_left != '0);
    assign natural_last = pop_ok && (words_left == CNT_W'(1));
    // A flush coinciding with the natural last pop changes nothing.
    assign flush_hit    = flush && (state == BURST) && !natural_last;
    // With words buffered, flush retags the youngest one instead of popping.
    // With the buffer empty, the next popped word (possibly this cycle's)
    // becomes the last one.
    assign set_last     = flush_hit && buf_nonempty;
    assign pop          = pop_ok && !set_last;
    assign push_last    = (words_left == CNT_W'(1)) || term_pending || flush_hit;

    assign fifo_deque_en = pop;
    assign burst_done    = m_valid && m_ready && m_last;

    out_skid_buf #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .push      (pop),
        .push_data (fifo_data),
        .push_last (push_last),
        .set_last  (set_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            words_left   <= '0;
            term_pending <= 1'b0;
            burst_count  <= '0;
        end else begin
            if (burst_done)
                burst_count <= burst_count + 32'd1;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= BURST;
                        words_left <= RELOAD;
                    end
                end
                BURST: begin
                    if (set_last) begin
                        // The retagged word can be the head transferring now,
                        // in which case the burst is already complete.
                        if (burst_done) begin
                            if (enable)
                                words_left <= RELOAD;
                            else
                                state <= IDLE;
                        end else begin
                            state <= WAIT_LAST;
                        end
                    end else if (pop) begin
                        words_left <= words_left - CNT_W'(1);
                        if (push_last) begin
                            state        <= WAIT_LAST;
                            term_pending <= 1'b0;
                        end
                    end else if (flush_hit) begin
                        term_pending <= 1'b1;
                    end
                end
                WAIT_LAST: begin
                    if (burst_done) begin
                        if (enable) begin
                            state      <= BURST;
                            words_left <= RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed self-checking bench for fifo_burst_reader
// with a queue-based first-word-fall-through FIFO model.
module tb_fifo_burst_reader;

    localparam int DW = 64;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_valid = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_deque_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          burst_done;
    logic [31:0]   burst_count;

    fifo_burst_reader #(
        .DWIDTH   (DW),
        .BURST_LEN(BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .fifo_valid   (fifo_valid),
        .fifo_data    (fifo_data),
        .fifo_deque_en(fifo_deque_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .burst_done   (burst_done),
        .burst_count  (burst_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    int errors = 0;
    int checks = 0;

    // values seen at the falling edge preceding the next active edge
    logic          s_valid, s_last, s_deq, s_done, s_ready, s_fv;
    logic [DW-1:0] s_data;

    typedef struct {
        logic          en, rdy, fl;
        logic          v;
        logic [DW-1:0] d;
        logic          l, deq, done;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic en, logic rdy, logic fl, logic v,
                                logic [DW-1:0] d, logic l, logic deq, logic done);
        vec_t r;
        r.en = en; r.rdy = rdy; r.fl = fl; r.v = v;
        r.d = d; r.l = l; r.deq = deq; r.done = done;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_valid = (q.size() != 0);
        fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    // One clock: sample at negedge, let the edge happen, then update FIFO model.
    task automatic cyc();
        @(negedge clk);
        s_valid = m_valid; s_data = m_data; s_last = m_last;
        s_deq = fifo_deque_en; s_done = burst_done; s_ready = m_ready;
        s_fv = fifo_valid;
        chk("deq_guard", {63'd0, s_deq & ~s_fv}, 64'd0);
        @(posedge clk);
        #1;
        if (s_deq && q.size() > 0) void'(q.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        q.delete();
        refresh();
        rst = 1'b0;
        #1;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_deq", {63'd0, fifo_deque_en}, 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_done", {63'd0, burst_done}, 64'd0);
        chk("rst_count", {32'd0, burst_count}, 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int nx;
        int mocc;
        int ndone;
        logic [3:0] rpat;

        rst = 1'b1;
        #1;

        // ---- 1: two back-to-back bursts, words 1..16, m_ready held high ----
        tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[2] = mk(1, 1, 0, 1, 1, 0, 1, 0);
        tbl[3] = mk(1, 1, 0, 1, 2, 0, 1, 0);
        tbl[4] = mk(1, 1, 0, 1, 3, 0, 1, 0);
        tbl[5] = mk(1, 1, 0, 1, 4, 0, 1, 0);
        tbl[6] = mk(1, 1, 0, 1, 5, 0, 1, 0);
        tbl[7] = mk(1, 1, 0, 1, 6, 0, 1, 0);
        tbl[8] = mk(1, 1, 0, 1, 7, 0, 1, 0);
        tbl[9] = mk(1, 1, 0, 1, 8, 1, 0, 1);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 1, 0, 1, 9, 0, 1, 0);
        tbl[12] = mk(1, 1, 0, 1, 10, 0, 1, 0);
        tbl[13] = mk(1, 1, 0, 1, 11, 0, 1, 0);
        tbl[14] = mk(1, 1, 0, 1, 12, 0, 1, 0);
        tbl[15] = mk(1, 1, 0, 1, 13, 0, 1, 0);
        tbl[16] = mk(1, 1, 0, 1, 14, 0, 1, 0);
        tbl[17] = mk(1, 1, 0, 1, 15, 0, 1, 0);
        tbl[18] = mk(0, 1, 0, 1, 16, 1, 0, 1);
        tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 1; i <= 16; i++) q.push_back(DW'(i));
        refresh();
        for (int i = 0; i < 20; i++) begin
            enable = tbl[i].en; m_ready = tbl[i].rdy; flush = tbl[i].fl;
            cyc();
            chk($sformatf("t1_valid[%0d]", i), {63'd0, s_valid}, {63'd0, tbl[i].v});
            chk($sformatf("t1_deq[%0d]", i), {63'd0, s_deq}, {63'd0, tbl[i].deq});
            chk($sformatf("t1_done[%0d]", i), {63'd0, s_done}, {63'd0, tbl[i].done});
            if (tbl[i].v) begin
                chk($sformatf("t1_data[%0d]", i), s_data, tbl[i].d);
                chk($sformatf("t1_last[%0d]", i), {63'd0, s_last}, {63'd0, tbl[i].l});
            end
        end
        chk("t1_count", {32'd0, burst_count}, 64'd2);
        chk("t1_fifo_empty", 64'(q.size()), 64'd0);

        // ---- 2: m_ready pattern 1,0,0,1 with 8 words ----
        do_reset();
        for (int i = 1; i <= 8; i++) q.push_back(DW'(i));
        refresh();
        rpat = 4'b1001;
        nx = 1; mocc = 0; ndone = 0;
        for (int i = 0; i < 60 && ndone == 0; i++) begin
            enable  = (i == 0);
            m_ready = rpat[i % 4];
            cyc();
            chk("t2_occ_le2", {63'd0, mocc <= 2}, 64'd1);
            chk("t2_valid_vs_occ", {63'd0, s_valid}, {63'd0, mocc != 0});
            if (mocc == 2) chk("t2_no_deq_full", {63'd0, s_deq}, 64'd0);
            if (s_valid && s_ready) begin
                chk("t2_data", s_data, DW'(nx));
                chk("t2_last", {63'd0, s_last}, {63'd0, nx == 8});
                nx++;
            end
            mocc = mocc + int'(s_deq) - int'(s_valid & s_ready);
            if (s_done) ndone++;
        end
        chk("t2_words", 64'(nx), 64'd9);
        chk("t2_count", {32'd0, burst_count}, 64'd1);

        // ---- 3: flush while word 102 is buffered but not sent ----
        do_reset();
        q.push_back(DW'(100)); q.push_back(DW'(101)); q.push_back(DW'(102));
        refresh();
        m_ready = 1'b0; enable = 1'b1;
        cyc(); chk("t3_r0_deq", {63'd0, s_deq}, 64'd0);
        enable = 1'b0;
        cyc(); chk("t3_r1_deq", {63'd0, s_deq}, 64'd1);
        cyc(); chk("t3_r2_data", s_data, 64'd100); chk("t3_r2_deq", {63'd0, s_deq}, 64'd1);
        m_ready = 1'b1;
        cyc(); chk("t3_r3_data", s_data, 64'd100); chk("t3_r3_deq_full", {63'd0, s_deq}, 64'd0);
        cyc(); chk("t3_r4_data", s_data, 64'd101); chk("t3_r4_deq", {63'd0, s_deq}, 64'd1);
        m_ready = 1'b0; flush = 1'b1;
        cyc(); chk("t3_r5_data", s_data, 64'd102); chk("t3_r5_last", {63'd0, s_last}, 64'd1);
        chk("t3_r5_done", {63'd0, s_done}, 64'd0);
        flush = 1'b0;
        cyc(); chk("t3_r6_last", {63'd0, s_last}, 64'd1); chk("t3_r6_deq", {63'd0, s_deq}, 64'd0);
        m_ready = 1'b1;
        cyc(); chk("t3_r7_done", {63'd0, s_done}, 64'd1); chk("t3_r7_data", s_data, 64'd102);
        chk("t3_count", {32'd0, burst_count}, 64'd1);
        q.push_back(DW'(7)); refresh();
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("t3_idle_deq", {63'd0, s_deq}, 64'd0);
        end
        enable = 1'b1;
        cyc(); enable = 1'b0;
        cyc(); chk("t3_rearm_deq", {63'd0, s_deq}, 64'd1);

        // ---- 4: flush with FIFO and buffer empty, then word 55 arrives ----
        do_reset();
        m_ready = 1'b1; enable = 1'b1;
        cyc();
        enable = 1'b0; flush = 1'b1;
        cyc(); chk("t4_r1_deq", {63'd0, s_deq}, 64'd0); chk("t4_r1_valid", {63'd0, s_valid}, 64'd0);
        flush = 1'b0;
        cyc(); chk("t4_r2_deq", {63'd0, s_deq}, 64'd0);
        q.push_back(DW'(55)); refresh();
        cyc(); chk("t4_r3_deq", {63'd0, s_deq}, 64'd1);
        ndone = 0;
        cyc(); chk("t4_r4_data", s_data, 64'd55); chk("t4_r4_last", {63'd0, s_last}, 64'd1);
        if (s_done) ndone++;
        for (int i = 0; i < 4; i++) begin
            cyc(); if (s_done) ndone++;
        end
        chk("t4_done_pulses", 64'(ndone), 64'd1);
        chk("t4_count", {32'd0, burst_count}, 64'd1);

        // ---- 5: enable dropped after word 3 ----
        do_reset();
        for (int i = 1; i <= 12; i++) q.push_back(DW'(i));
        refresh();
        m_ready = 1'b1; enable = 1'b1;
        nx = 1; ndone = 0;
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            cyc();
            if (s_valid && s_ready) begin
                chk("t5_data", s_data, DW'(nx));
                chk("t5_last", {63'd0, s_last}, {63'd0, nx == 8});
                nx++;
                if (nx == 4) enable = 1'b0;
            end
            if (s_done) ndone++;
        end
        chk("t5_words", 64'(nx), 64'd9);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_idle_deq", {63'd0, s_deq}, 64'd0);
            chk("t5_idle_valid", {63'd0, s_valid}, 64'd0);
        end
        chk("t5_fifo_left", 64'(q.size()), 64'd4);

        // ---- 6: asynchronous reset with two words buffered ----
        do_reset();
        for (int i = 1; i <= 12; i++) q.push_back(DW'(i));
        refresh();
        m_ready = 1'b0; enable = 1'b1;
        cyc(); cyc(); cyc();
        chk("t6_pre_valid", {63'd0, m_valid}, 64'd1);
        chk("t6_pre_full_deq", {63'd0, fifo_deque_en}, 64'd0);
        rst = 1'b0;
        #1;
        chk("t6_async_valid", {63'd0, m_valid}, 64'd0);
        chk("t6_async_deq", {63'd0, fifo_deque_en}, 64'd0);
        chk("t6_async_count", {32'd0, burst_count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; m_ready = 1'b1; enable = 1'b1;
        nx = 3; ndone = 0;
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            cyc();
            enable = 1'b0;
            if (s_valid && s_ready) begin
                chk("t6_data", s_data, DW'(nx));
                chk("t6_last", {63'd0, s_last}, {63'd0, nx == 10});
                nx++;
            end
            if (s_done) ndone++;
        end
        chk("t6_words", 64'(nx), 64'd11);
        chk("t6_count", {32'd0, burst_count}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
